// File: rtl/vint_ctrl_if.sv
// Bus between the vectored interrupt controller, its request sources and the CPU level input.
// The slave modport is the controller's view; the master modport drives sources and strobe.
interface vint_ctrl_if #(
    parameter int unsigned N_SRC = 8
);
    logic [N_SRC-1:0]   src_req;
    logic [9*N_SRC-1:0] src_vec;
    logic [N_SRC-1:0]   src_iack;
    logic               irq;
    logic               istb;
    logic [8:0]         ivec;
    logic               iack;

    modport slave (
        input  src_req,
        input  src_vec,
        input  istb,
        output src_iack,
        output irq,
        output ivec,
        output iack
    );

    modport master (
        output src_req,
        output src_vec,
        output istb,
        input  src_iack,
        input  irq,
        input  ivec,
        input  iack
    );
endinterface

// File: rtl/vint_ctrl.sv
// Vectored interrupt controller for one bus request level: fixed-priority merge of
// N_SRC requests into irq, vector return on CPU strobe, one-cycle source acknowledge.
module vint_ctrl #(
    parameter int unsigned N_SRC = 8
) (
    input  logic         clk_p,
    input  logic         rst,
    vint_ctrl_if.slave   bus
);
    localparam int unsigned WIN_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned VEC_W = 9;

    typedef enum logic [1:0] {IDLE, SEL, ACK} state_t;

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   win, win_nxt, win_pick;
    logic               hit, hit_nxt;
    logic [VEC_W-1:0]   ivec_q, ivec_nxt, vec_sel;
    logic               iack_q, iack_nxt;
    logic [N_SRC-1:0]   src_iack_q, src_iack_nxt;

    // Lowest-index pending request wins.
    always_comb begin
        win_pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bus.src_req[i]) win_pick = WIN_W'(i);
        end
    end

    // Vector of the latched winner, sampled live in SEL.
    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win == WIN_W'(i)) vec_sel = bus.src_vec[VEC_W*i +: VEC_W];
        end
    end

    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win        <= '0;
            hit        <= 1'b0;
            ivec_q     <= '0;
            iack_q     <= 1'b0;
            src_iack_q <= '0;
        end else begin
            state      <= state_nxt;
            win        <= win_nxt;
            hit        <= hit_nxt;
            ivec_q     <= ivec_nxt;
            iack_q     <= iack_nxt;
            src_iack_q <= src_iack_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        win_nxt      = win;
        hit_nxt      = hit;
        ivec_nxt     = ivec_q;
        iack_nxt     = 1'b0;
        src_iack_nxt = '0;
        unique case (state)
            IDLE: begin
                if (bus.istb) begin
                    win_nxt   = win_pick;
                    hit_nxt   = |bus.src_req;
                    state_nxt = SEL;
                end
            end
            SEL: begin
                if (!bus.istb) begin
                    state_nxt = IDLE;
                end else begin
                    // A miss still completes the handshake with a null vector.
                    ivec_nxt  = hit ? vec_sel : '0;
                    if (hit) src_iack_nxt = N_SRC'(1) << win;
                    iack_nxt  = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!bus.istb) begin
                    state_nxt = IDLE;
                end else begin
                    iack_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // irq stays up through the handshake because the CPU gates istb with it.
    assign bus.irq      = (state == IDLE) ? |bus.src_req : 1'b1;
    assign bus.ivec     = ivec_q;
    assign bus.iack     = iack_q;
    assign bus.src_iack = src_iack_q;
endmodule

// File: tb/tb_vint_ctrl.sv
// Directed bench for vint_ctrl: single source, priority order, passive release,
// abort, reset mid-handshake and irq hold.
module tb_vint_ctrl;
    localparam int unsigned N = 8;

    logic clk_p = 1'b0;
    logic rst   = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vint_ctrl_if #(.N_SRC(N)) bus ();
    vint_ctrl #(.N_SRC(N)) dut (.clk_p(clk_p), .rst(rst), .bus(bus));

    always #5 clk_p = ~clk_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o (octal)", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic set_vec(input int idx, input logic [8:0] v);
        bus.src_vec[9*idx +: 9] = v;
    endtask

    // Full handshake: strobe, check vector/acks, device drops request, release strobe.
    task automatic strobe(input string tag, input logic [8:0] exp_vec, input logic [7:0] exp_ack);
        bus.istb = 1'b1;
        tick();
        check({tag, "_sel_iack"}, 32'(bus.iack), 32'd0);
        tick();
        check({tag, "_iack"}, 32'(bus.iack), 32'd1);
        check({tag, "_ivec"}, 32'(bus.ivec), 32'(exp_vec));
        check({tag, "_src_iack"}, 32'(bus.src_iack), 32'(exp_ack));
        bus.src_req = bus.src_req & ~exp_ack;
        tick();
        check({tag, "_src_iack_pulse"}, 32'(bus.src_iack), 32'd0);
        check({tag, "_iack_held"}, 32'(bus.iack), 32'd1);
        check({tag, "_irq_held"}, 32'(bus.irq), 32'd1);
        bus.istb = 1'b0;
        tick();
        check({tag, "_iack_fall"}, 32'(bus.iack), 32'd0);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_req = '0;
        bus.src_vec = '0;
        bus.istb    = 1'b0;
        tick();
        tick();
        check("rst_iack", 32'(bus.iack), 32'd0);
        check("rst_ivec", 32'(bus.ivec), 32'd0);
        check("rst_src_iack", 32'(bus.src_iack), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        rst = 1'b0;
        tick();

        // Single source
        set_vec(3, 9'o060);
        bus.src_req = 8'b0000_1000;
        #1;
        check("single_irq", 32'(bus.irq), 32'd1);
        strobe("single", 9'o060, 8'b0000_1000);
        check("single_irq_low", 32'(bus.irq), 32'd0);

        // Priority order
        set_vec(2, 9'o070);
        set_vec(5, 9'o300);
        set_vec(7, 9'o310);
        bus.src_req = 8'b1010_0100;
        #1;
        strobe("prio0", 9'o070, 8'b0000_0100);
        check("prio0_irq", 32'(bus.irq), 32'd1);
        strobe("prio1", 9'o300, 8'b0010_0000);
        check("prio1_irq", 32'(bus.irq), 32'd1);
        strobe("prio2", 9'o310, 8'b1000_0000);
        check("prio2_irq", 32'(bus.irq), 32'd0);

        // Passive release
        bus.istb = 1'b1;
        tick();
        check("pass_sel_irq", 32'(bus.irq), 32'd1);
        tick();
        check("pass_iack", 32'(bus.iack), 32'd1);
        check("pass_ivec", 32'(bus.ivec), 32'o000);
        check("pass_src_iack", 32'(bus.src_iack), 32'd0);
        bus.istb = 1'b0;
        tick();
        check("pass_iack_fall", 32'(bus.iack), 32'd0);
        tick();

        // Abort: load a known vector, then a one-cycle strobe with a pending source
        bus.src_req = 8'b0000_1000;
        strobe("abort_pre", 9'o060, 8'b0000_1000);
        set_vec(1, 9'o100);
        bus.src_req = 8'b0000_0010;
        bus.istb = 1'b1;
        tick();
        bus.istb = 1'b0;
        tick();
        check("abort_iack", 32'(bus.iack), 32'd0);
        check("abort_src_iack", 32'(bus.src_iack), 32'd0);
        check("abort_ivec", 32'(bus.ivec), 32'o060);
        tick();
        check("abort_iack2", 32'(bus.iack), 32'd0);
        check("abort_src_iack2", 32'(bus.src_iack), 32'd0);
        check("abort_irq", 32'(bus.irq), 32'd1);
        strobe("abort_post", 9'o100, 8'b0000_0010);

        // Reset while in ACK
        bus.src_req = 8'b0000_1000;
        bus.istb = 1'b1;
        tick();
        tick();
        check("rstmid_iack_pre", 32'(bus.iack), 32'd1);
        check("rstmid_src_iack_pre", 32'(bus.src_iack), 32'b0000_1000);
        rst = 1'b1;
        #1;
        check("rstmid_iack", 32'(bus.iack), 32'd0);
        check("rstmid_ivec", 32'(bus.ivec), 32'd0);
        check("rstmid_src_iack", 32'(bus.src_iack), 32'd0);
        bus.istb = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_idle_iack", 32'(bus.iack), 32'd0);
        check("rstmid_idle_irq", 32'(bus.irq), 32'd1);
        bus.src_req = '0;
        #1;
        check("rstmid_irq_follow", 32'(bus.irq), 32'd0);
        tick();

        // irq hold: request withdrawn after sampling
        set_vec(4, 9'o200);
        bus.src_req = 8'b0001_0000;
        bus.istb = 1'b1;
        tick();
        bus.src_req = '0;
        #1;
        check("hold_irq_sel", 32'(bus.irq), 32'd1);
        tick();
        check("hold_iack", 32'(bus.iack), 32'd1);
        check("hold_ivec", 32'(bus.ivec), 32'o200);
        check("hold_src_iack", 32'(bus.src_iack), 32'b0001_0000);
        check("hold_irq_ack", 32'(bus.irq), 32'd1);
        bus.istb = 1'b0;
        tick();
        check("hold_iack_fall", 32'(bus.iack), 32'd0);
        check("hold_irq_idle", 32'(bus.irq), 32'd0);
        check("hold_ivec_kept", 32'(bus.ivec), 32'o200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
